// File: rtl/fpu_mult_seq.sv
// fpu_mult_seq: initiator side of the FPU mantissa multiplier interface.
// Latches one multiply request, then steps through the single (2-step) or
// double (4-step) function-code sequence. It collects one 32-bit result word
// per step LAT non-held cycles later, and then assembles the truncated 64-bit
// product with its sticky and overflow flags.
// Ports:
//   clk, reset_l          clock, async active-low reset
//   fpuhold               global freeze (no state change while high)
//   start, op_dbl         request strobe (IDLE only), 1 = double / 0 = single
//   opa, opb              53-bit mantissas
//   multout, movf         result word / overflow returned by the multiplier
//   ma1/ma0, mb1/mb0      latched operand halves driven to the multiplier
//   nx_multfunc_rom0/1    current / lookahead function code
//   romsel, nx_cyc0_rdy   sequence select, step-0 marker
//   busy, done            not-idle flag, one-cycle completion pulse
//   prod, sticky, ovf     assembled result, held until next accepted start
module fpu_mult_seq #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        fpuhold,
  input  logic        start,
  input  logic        op_dbl,
  input  logic [52:0] opa,
  input  logic [52:0] opb,
  input  logic [31:0] multout,
  input  logic        movf,
  output logic [31:0] ma1,
  output logic [20:0] ma0,
  output logic [31:0] mb1,
  output logic [20:0] mb0,
  output logic [3:0]  nx_multfunc_rom0,
  output logic [3:0]  nx_multfunc_rom1,
  output logic [1:0]  romsel,
  output logic        nx_cyc0_rdy,
  output logic        busy,
  output logic        done,
  output logic [63:0] prod,
  output logic        sticky,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             step_q, step_d;
  logic                   dbl_q, dbl_d;
  logic [52:0]            opa_q, opa_d, opb_q, opb_d;
  // Capture pipeline: entry i holds the step issued i+1 non-held cycles ago.
  logic [LAT-1:0]         pv_q, pv_d;
  logic [LAT-1:0][1:0]    pidx_q, pidx_d;
  logic [127:0]           p_q, p_d;
  logic [63:0]            prod_q, prod_d;
  logic                   sticky_q, sticky_d, ovf_q, ovf_d;
  logic [3:0]             rom0_q, rom0_d, rom1_q, rom1_d;
  logic [1:0]             romsel_q, romsel_d;
  logic                   cyc0_q, cyc0_d, busy_q, busy_d, done_q, done_d;

  logic                   cap;
  logic [1:0]             cidx, last_q, last_d;

  function automatic logic [3:0] code_of(input logic dbl, input logic [1:0] k);
    return dbl ? (4'h3 + {2'b00, k}) : (4'h1 + {2'b00, k});
  endfunction

  assign cap    = pv_q[LAT-1];
  assign cidx   = pidx_q[LAT-1];
  assign last_q = dbl_q ? 2'd3 : 2'd1;
  assign last_d = dbl_d ? 2'd3 : 2'd1;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dbl_d    = dbl_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    pv_d     = pv_q;
    pidx_d   = pidx_q;
    p_d      = p_q;
    prod_d   = prod_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;

    if (!fpuhold) begin
      pv_d[0]   = (state_q == StIssue);
      pidx_d[0] = step_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        pv_d[i]   = pv_q[i-1];
        pidx_d[i] = pidx_q[i-1];
      end

      if (cap) begin
        p_d[{cidx, 5'd0} +: 32] = multout;
        ovf_d                   = ovf_q | movf;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            dbl_d    = op_dbl;
            opa_d    = opa;
            opb_d    = opb;
            p_d      = '0;
            prod_d   = '0;
            sticky_d = 1'b0;
            ovf_d    = 1'b0;
            step_d   = 2'd0;
            state_d  = StIssue;
          end
        end
        StIssue: begin
          if (step_q == last_q) state_d = StDrain;
          else                  step_d  = step_q + 2'd1;
        end
        StDrain: begin
          if (cap && (cidx == last_q)) begin
            state_d = StDone;
            // Assembly sees the word captured on this same edge via p_d.
            if (dbl_q) begin
              prod_d   = p_d[105:42];
              sticky_d = |p_d[41:0];
            end else begin
              prod_d   = {p_d[47:0], 16'h0000};
              sticky_d = 1'b0;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          opa_d   = '0;
          opb_d   = '0;
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered: decode them from the next state.
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    romsel_d = (state_d == StIssue) ? (dbl_d ? 2'b10 : 2'b01) : 2'b00;
    rom0_d   = (state_d == StIssue) ? code_of(dbl_d, step_d) : 4'h0;
    rom1_d   = ((state_d == StIssue) && (step_d != last_d)) ?
               code_of(dbl_d, step_d + 2'd1) : 4'h0;
    cyc0_d   = (state_d == StIssue) && (step_d == 2'd0);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= StIdle;
      step_q   <= '0;
      dbl_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      pv_q     <= '0;
      pidx_q   <= '0;
      p_q      <= '0;
      prod_q   <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      rom0_q   <= '0;
      rom1_q   <= '0;
      romsel_q <= '0;
      cyc0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dbl_q    <= dbl_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      pv_q     <= pv_d;
      pidx_q   <= pidx_d;
      p_q      <= p_d;
      prod_q   <= prod_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      rom0_q   <= rom0_d;
      rom1_q   <= rom1_d;
      romsel_q <= romsel_d;
      cyc0_q   <= cyc0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ma1              = opa_q[52:21];
  assign ma0              = opa_q[20:0];
  assign mb1              = opb_q[52:21];
  assign mb0              = opb_q[20:0];
  assign nx_multfunc_rom0 = rom0_q;
  assign nx_multfunc_rom1 = rom1_q;
  assign romsel           = romsel_q;
  assign nx_cyc0_rdy      = cyc0_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign prod             = prod_q;
  assign sticky           = sticky_q;
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_fpu_mult_seq.sv
// Bench for fpu_mult_seq: directed vectors with hand-computed results and a
// small behavioural multiplier that answers function codes LAT cycles later.
module tb_fpu_mult_seq;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset_l, fpuhold, start, op_dbl;
  logic [52:0] opa, opb;
  logic [31:0] multout;
  logic        movf;
  logic [31:0] ma1, mb1;
  logic [20:0] ma0, mb0;
  logic [3:0]  rom0, rom1;
  logic [1:0]  romsel;
  logic        cyc0, busy, done, sticky, ovf;
  logic [63:0] prod;

  int n_total = 0;
  int n_bad   = 0;

  fpu_mult_seq #(.LAT(LAT)) dut (
    .clk              (clk),
    .reset_l          (reset_l),
    .fpuhold          (fpuhold),
    .start            (start),
    .op_dbl           (op_dbl),
    .opa              (opa),
    .opb              (opb),
    .multout          (multout),
    .movf             (movf),
    .ma1              (ma1),
    .ma0              (ma0),
    .mb1              (mb1),
    .mb0              (mb0),
    .nx_multfunc_rom0 (rom0),
    .nx_multfunc_rom1 (rom1),
    .romsel           (romsel),
    .nx_cyc0_rdy      (cyc0),
    .busy             (busy),
    .done             (done),
    .prod             (prod),
    .sticky           (sticky),
    .ovf              (ovf)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: maps a function code to a word index and returns
  // that word of the full product LAT non-held cycles later.
  logic           ovf_inj;
  logic [1:0]     mv;
  logic [1:0]     midx0, midx1;
  logic [127:0]   full;

  assign full    = {75'd0, ma1, ma0} * {75'd0, mb1, mb0};
  assign multout = mv[1] ? full[{midx1, 5'd0} +: 32] : 32'h0;
  assign movf    = mv[1] && ovf_inj && (midx1 == 2'd0);

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      mv    <= '0;
      midx0 <= '0;
      midx1 <= '0;
    end else if (!fpuhold) begin
      mv[0] <= (rom0 != 4'h0);
      midx0 <= (rom0 >= 4'h3) ? 2'(rom0 - 4'h3) : 2'(rom0 - 4'h1);
      mv[1] <= mv[0];
      midx1 <= midx0;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rom0_log [0:15];
  logic [3:0] rom1_log [0:15];
  logic [1:0] rsel_log [0:15];
  logic       cyc0_log [0:15];

  // Issue one request from the current (idle) cycle; n_done is the cycle of
  // the done pulse relative to the accepting edge, or -1 on timeout.
  task automatic run_op(input logic dbl, input logic [52:0] a, input logic [52:0] b,
                        output int n_done);
    int  n;
    logic seen;
    op_dbl = dbl;
    opa    = a;
    opb    = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    n      = 1;
    seen   = 1'b0;
    while (!seen && n < 15) begin
      rom0_log[n] = rom0;
      rom1_log[n] = rom1;
      rsel_log[n] = romsel;
      cyc0_log[n] = cyc0;
      if (done) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    n_done = seen ? n : -1;
  endtask

  task automatic wait_done(input int n0, output int n_done);
    int n;
    n = n0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    n_done = done ? n : -1;
  endtask

  initial begin
    int nd;
    int cnt;
    int n;
    int dcyc [0:2];
    int c0;

    reset_l = 1'b0;
    fpuhold = 1'b0;
    start   = 1'b0;
    op_dbl  = 1'b0;
    opa     = '0;
    opb     = '0;
    ovf_inj = 1'b0;
    step();
    step();
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_romsel", 128'(romsel), 128'(0));
    check_eq("rst_prod", 128'(prod), 128'(0));
    check_eq("rst_ma", 128'({ma1, ma0, mb1, mb0}), 128'(0));
    reset_l = 1'b1;
    step();

    // Single 2^23 * 2^23
    run_op(1'b0, 53'h80_0000, 53'h80_0000, nd);
    check_eq("s_done_cyc", 128'(nd), 128'(5));
    check_eq("s_rom0_0", 128'(rom0_log[1]), 128'(4'h1));
    check_eq("s_rom0_1", 128'(rom0_log[2]), 128'(4'h2));
    check_eq("s_rom1_0", 128'(rom1_log[1]), 128'(4'h2));
    check_eq("s_rom1_1", 128'(rom1_log[2]), 128'(4'h0));
    check_eq("s_romsel", 128'({rsel_log[1], rsel_log[2], rsel_log[3]}), 128'(6'b01_01_00));
    check_eq("s_prod", 128'(prod), 128'(64'h4000_0000_0000_0000));
    check_eq("s_sticky", 128'(sticky), 128'(0));
    check_eq("s_ovf", 128'(ovf), 128'(0));
    check_eq("s_busy_done", 128'(busy), 128'(1));
    step();
    check_eq("s_idle_busy", 128'(busy), 128'(0));
    check_eq("s_idle_ma", 128'(ma1), 128'(0));

    // Double 2^52 * 2^52
    run_op(1'b1, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000, nd);
    check_eq("d_done_cyc", 128'(nd), 128'(7));
    check_eq("d_rom0", 128'({rom0_log[1], rom0_log[2], rom0_log[3], rom0_log[4]}),
             128'(16'h3456));
    check_eq("d_rom1", 128'({rom1_log[1], rom1_log[2], rom1_log[3], rom1_log[4]}),
             128'(16'h4560));
    check_eq("d_romsel", 128'({rsel_log[1], rsel_log[4], rsel_log[5]}), 128'(6'b10_10_00));
    c0 = 0;
    for (int i = 1; i <= 7; i++) c0 += int'(cyc0_log[i]);
    check_eq("d_cyc0_t1", 128'(cyc0_log[1]), 128'(1));
    check_eq("d_cyc0_cnt", 128'(c0), 128'(1));
    check_eq("d_prod", 128'(prod), 128'(64'h4000_0000_0000_0000));
    check_eq("d_sticky", 128'(sticky), 128'(0));
    step();

    // Double (2^52+1)^2 = 2^104 + 2^53 + 1
    run_op(1'b1, 53'h10_0000_0000_0001, 53'h10_0000_0000_0001, nd);
    check_eq("d1_done_cyc", 128'(nd), 128'(7));
    check_eq("d1_prod", 128'(prod), 128'(64'h4000_0000_0000_0800));
    check_eq("d1_sticky", 128'(sticky), 128'(1));
    check_eq("d1_ovf", 128'(ovf), 128'(0));
    step();

    // Single 0xFFFFFF^2 with a 3-cycle hold during step 1, movf on word 0
    ovf_inj = 1'b1;
    op_dbl  = 1'b0;
    opa     = 53'hFF_FFFF;
    opb     = 53'hFF_FFFF;
    start   = 1'b1;
    step();
    start   = 1'b0;
    check_eq("h_rom0_s0", 128'(rom0), 128'(4'h1));
    step();
    check_eq("h_rom0_s1", 128'(rom0), 128'(4'h2));
    fpuhold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("h_frz_rom0", 128'(rom0), 128'(4'h2));
      check_eq("h_frz_rsel", 128'(romsel), 128'(2'b01));
      check_eq("h_frz_ovf", 128'(ovf), 128'(0));
    end
    fpuhold = 1'b0;
    wait_done(5, nd);
    ovf_inj = 1'b0;
    check_eq("h_done_cyc", 128'(nd), 128'(8));
    check_eq("h_prod", 128'(prod), 128'(64'hFFFF_FE00_0001_0000));
    check_eq("h_ovf", 128'(ovf), 128'(1));
    check_eq("h_sticky", 128'(sticky), 128'(0));
    step();

    // Reset at step 2 of a double, then a fresh single
    op_dbl = 1'b1;
    opa    = 53'h10_0000_0000_0001;
    opb    = 53'h10_0000_0000_0001;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    step();
    check_eq("r_pre_rom0", 128'(rom0), 128'(4'h5));
    reset_l = 1'b0;
    #1;
    check_eq("r_busy", 128'(busy), 128'(0));
    check_eq("r_rom", 128'({rom0, rom1, romsel}), 128'(0));
    check_eq("r_ma", 128'({ma1, ma0, mb1, mb0}), 128'(0));
    check_eq("r_flags", 128'({ovf, sticky}), 128'(0));
    check_eq("r_prod", 128'(prod), 128'(0));
    reset_l = 1'b1;
    step();
    run_op(1'b0, 53'h80_0000, 53'h80_0000, nd);
    check_eq("r_s_done_cyc", 128'(nd), 128'(5));
    check_eq("r_s_prod", 128'(prod), 128'(64'h4000_0000_0000_0000));
    check_eq("r_s_flags", 128'({ovf, sticky}), 128'(0));
    step();

    // start held high: one single accepted every 6 cycles
    op_dbl = 1'b0;
    opa    = 53'h80_0000;
    opb    = 53'h80_0000;
    start  = 1'b1;
    cnt    = 0;
    n      = 0;
    while (cnt < 3 && n < 60) begin
      step();
      n++;
      if (done) begin
        dcyc[cnt] = n;
        cnt++;
        if (cnt < 3) begin
          step();
          n++;
          check_eq("b_idle_busy", 128'(busy), 128'(0));
        end
      end
    end
    start = 1'b0;
    check_eq("b_cnt", 128'(cnt), 128'(3));
    if (cnt == 3) begin
      check_eq("b_first", 128'(dcyc[0]), 128'(5));
      check_eq("b_gap1", 128'(dcyc[1] - dcyc[0]), 128'(6));
      check_eq("b_gap2", 128'(dcyc[2] - dcyc[1]), 128'(6));
    end
    check_eq("b_prod", 128'(prod), 128'(64'h4000_0000_0000_0000));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
